// File: rtl/z3_target_engine.sv
// Zorro III target cycle engine: window decode, FCS/DS/DTACK handshake,
// multiple-transfer bursts and ack-timeout bus error.
module z3_target_engine #(
  parameter int unsigned                   NUM_REGIONS = 4,
  parameter int unsigned                   ADDR_W      = 24,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
  parameter logic [NUM_REGIONS-1:0]        MT_REGIONS  = '0,
  parameter int unsigned                   TIMEOUT     = 32,
  parameter int unsigned                   BEAT_W      = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_fcs_n,
  input  logic                   i_match,
  input  logic                   i_valid_space,
  input  logic                   i_read,
  input  logic [3:0]             i_ds_n,
  input  logic                   i_doe,
  input  logic                   i_mtcr_n,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [NUM_REGIONS-1:0] i_region_ack,
  output logic [NUM_REGIONS-1:0] o_region_sel,
  output logic [ADDR_W-1:0]      o_beat_addr,
  output logic                   o_data_phase,
  output logic                   o_dtack,
  output logic                   o_mtack,
  output logic                   o_bus_err,
  output logic [BEAT_W-1:0]      o_beat_cnt,
  output logic [2:0]             o_state
);

  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_END     = 3'd3,
    S_MT_WAIT = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_REGIONS-1:0] r_sel, w_sel_nxt;
  logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
  logic [BEAT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [TMR_W-1:0]       r_timer, w_timer_nxt;
  logic                   r_dtack, w_dtack_nxt;
  logic                   r_mtack, w_mtack_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_dphase, w_dphase_nxt;
  logic                   r_mtcr_q;

  logic [NUM_REGIONS-1:0] w_hit;
  logic [NUM_REGIONS-1:0] w_hit_oh;
  logic                   w_mt_sel;
  logic                   w_mtcr_rise;
  logic                   w_ack;
  logic [BEAT_W-1:0]      w_cnt_inc;
  logic [ADDR_W-1:0]      w_addr_inc;

  // Window decode; lowest index wins when windows overlap
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      w_hit[i] = ((i_addr ^ REGION_BASE[i*ADDR_W +: ADDR_W])
                  & REGION_MASK[i*ADDR_W +: ADDR_W]) == '0;
    end
    w_hit_oh = w_hit & (~w_hit + NUM_REGIONS'(1));
  end

  assign w_mt_sel    = |(MT_REGIONS & r_sel);
  assign w_mtcr_rise = i_mtcr_n & ~r_mtcr_q;
  assign w_ack       = |(i_region_ack & r_sel);
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + BEAT_W'(1);
  // Longword step within a 256-byte page: bits [7:2] wrap, no carry upward
  assign w_addr_inc  = {r_addr[ADDR_W-1:8], 6'(r_addr[7:2] + 6'd1), r_addr[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_dtack  <= 1'b0;
      r_mtack  <= 1'b0;
      r_err    <= 1'b0;
      r_dphase <= 1'b0;
      r_mtcr_q <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_timer  <= w_timer_nxt;
      r_dtack  <= w_dtack_nxt;
      r_mtack  <= w_mtack_nxt;
      r_err    <= w_err_nxt;
      r_dphase <= w_dphase_nxt;
      r_mtcr_q <= i_mtcr_n;
    end
  end

  // Next state and next register values
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    w_mtack_nxt = r_mtack;
    w_err_nxt   = r_err;

    if (r_state != S_IDLE && i_fcs_n) begin
      w_state_nxt = S_IDLE;
      w_sel_nxt   = '0;
      w_mtack_nxt = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_sel_nxt   = '0;
          w_mtack_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          if (!i_fcs_n && i_match && i_valid_space && |w_hit) begin
            w_state_nxt = S_START;
            w_sel_nxt   = w_hit_oh;
            w_addr_nxt  = i_addr;
            w_cnt_nxt   = '0;
          end
        end
        S_START: begin
          if (i_read || (i_doe && !(&i_ds_n))) begin
            w_state_nxt = S_DATA;
            w_timer_nxt = '0;
          end
        end
        S_DATA: begin
          w_timer_nxt = r_timer + TMR_W'(1);
          if (w_ack || r_timer == TMR_W'(TIMEOUT - 1)) begin
            w_state_nxt = S_END;
            w_err_nxt   = ~w_ack;
            w_cnt_nxt   = w_cnt_inc;
            w_mtack_nxt = w_mt_sel & ~i_mtcr_n;
          end
        end
        S_END: begin
          w_mtack_nxt = w_mt_sel & ~i_mtcr_n;
          if (w_mt_sel && w_mtcr_rise) begin
            w_state_nxt = S_MT_WAIT;
            w_mtack_nxt = 1'b1;
            w_err_nxt   = 1'b0;
          end
        end
        S_MT_WAIT: begin
          w_mtack_nxt = 1'b1;
          w_err_nxt   = 1'b0;
          if (!i_mtcr_n) begin
            w_state_nxt = S_DATA;
            w_timer_nxt = '0;
            w_addr_nxt  = w_addr_inc;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = '0;
          w_mtack_nxt = 1'b0;
          w_err_nxt   = 1'b0;
        end
      endcase
    end

    w_dtack_nxt  = (w_state_nxt == S_END);
    w_dphase_nxt = (w_state_nxt == S_DATA);
  end

  assign o_region_sel = r_sel;
  assign o_beat_addr  = r_addr;
  assign o_data_phase = r_dphase;
  assign o_dtack      = r_dtack;
  assign o_mtack      = r_mtack;
  assign o_bus_err    = r_err;
  assign o_beat_cnt   = r_cnt;
  assign o_state      = r_state;

endmodule

// File: tb/tb_z3_target_engine.sv
// Randomised scoreboard bench for z3_target_engine: expected beats are queued at
// issue time and compared by a monitor whenever DTACK is asserted.
module tb_z3_target_engine;

  localparam int unsigned TIMEOUT = 32;
  localparam logic [23:0] B0 = 24'h000000, M0 = 24'hFF0000;
  localparam logic [23:0] B1 = 24'h100000, M1 = 24'hFF0000;
  localparam logic [23:0] B2 = 24'h000000, M2 = 24'hFFF000;
  localparam logic [23:0] B3 = 24'h800000, M3 = 24'h800000;

  logic        i_clk = 1'b0;
  logic        i_reset, i_fcs_n, i_match, i_valid_space, i_read, i_doe, i_mtcr_n;
  logic [3:0]  i_ds_n;
  logic [23:0] i_addr;
  logic [3:0]  i_region_ack;
  logic [3:0]  o_region_sel;
  logic [23:0] o_beat_addr;
  logic        o_data_phase, o_dtack, o_mtack, o_bus_err;
  logic [7:0]  o_beat_cnt;
  logic [2:0]  o_state;

  z3_target_engine #(
    .NUM_REGIONS(4), .ADDR_W(24),
    .REGION_BASE({B3, B2, B1, B0}),
    .REGION_MASK({M3, M2, M1, M0}),
    .MT_REGIONS(4'b0001),
    .TIMEOUT(TIMEOUT), .BEAT_W(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_fcs_n(i_fcs_n), .i_match(i_match),
    .i_valid_space(i_valid_space), .i_read(i_read), .i_ds_n(i_ds_n),
    .i_doe(i_doe), .i_mtcr_n(i_mtcr_n), .i_addr(i_addr),
    .i_region_ack(i_region_ack), .o_region_sel(o_region_sel),
    .o_beat_addr(o_beat_addr), .o_data_phase(o_data_phase), .o_dtack(o_dtack),
    .o_mtack(o_mtack), .o_bus_err(o_bus_err), .o_beat_cnt(o_beat_cnt),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  sel;
    logic [23:0] addr;
    logic        err;
    logic [7:0]  cnt;
    logic        mtack;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference decode: first window whose compared bits all equal the base
  function automatic logic [3:0] ref_sel(input logic [23:0] a);
    logic [23:0] b[4];
    logic [23:0] m[4];
    b = '{B0, B1, B2, B3};
    m = '{M0, M1, M2, M3};
    for (int i = 0; i < 4; i++)
      if (((a ^ b[i]) & m[i]) == 24'h0) return 4'(1 << i);
    return 4'h0;
  endfunction

  function automatic logic [23:0] beat_addr(input logic [23:0] a, input int beat);
    int lw;
    lw = (int'(a[7:2]) + beat) % 64;
    return {a[23:8], 6'(lw), a[1:0]};
  endfunction

  // Monitor: every rising DTACK completes exactly one expected beat
  logic dtack_q = 1'b0;
  exp_t mon_e;
  always @(negedge i_clk) begin
    if (o_dtack === 1'b1 && dtack_q !== 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_dtack", 32'(o_dtack), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("beat_sel",   32'(o_region_sel), 32'(mon_e.sel));
        chk("beat_addr",  32'(o_beat_addr),  32'(mon_e.addr));
        chk("beat_err",   32'(o_bus_err),    32'(mon_e.err));
        chk("beat_cnt",   32'(o_beat_cnt),   32'(mon_e.cnt));
        chk("beat_mtack", 32'(o_mtack),      32'(mon_e.mtack));
        chk("beat_state", 32'(o_state),      32'd3);
      end
    end
    dtack_q = o_dtack;
  end

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic release_fcs(input logic [7:0] cnt);
    i_fcs_n = 1'b1;
    step();
    chk("rel_dtack", 32'(o_dtack), 32'd0);
    chk("rel_state", 32'(o_state), 32'd0);
    chk("rel_sel",   32'(o_region_sel), 32'd0);
    chk("rel_cnt",   32'(o_beat_cnt), 32'(cnt));
  endtask

  // One full cycle: ack_dly = DATA cycles before the selected ack is raised
  task automatic run_cycle(input logic [23:0] a, input bit rd, input int ack_dly, input bit match);
    exp_t e;
    logic [3:0] s;
    int n;
    bit hit;
    s   = ref_sel(a);
    hit = match && (s != 4'h0);
    i_addr = a; i_match = match; i_valid_space = 1'b1; i_read = rd;
    i_doe  = !rd;
    i_ds_n = rd ? 4'hF : 4'($urandom_range(0, 14));
    if (hit) begin
      e.sel = s; e.addr = a; e.err = (ack_dly > int'(TIMEOUT) - 1);
      e.cnt = 8'd1; e.mtack = 1'b0;
      exp_q.push_back(e);
    end
    i_fcs_n = 1'b0;
    step();
    if (!hit) begin
      repeat (4) step();
      chk("miss_state", 32'(o_state), 32'd0);
      chk("miss_dtack", 32'(o_dtack), 32'd0);
      chk("miss_sel",   32'(o_region_sel), 32'd0);
      i_fcs_n = 1'b1;
      step();
      return;
    end
    chk("start_state", 32'(o_state), 32'd1);
    chk("start_sel",   32'(o_region_sel), 32'(s));
    step();
    chk("data_entry",  32'(o_data_phase), 32'd1);
    n = 0;
    while (o_dtack !== 1'b1 && n < 64) begin
      i_region_ack = (n == ack_dly) ? s : (4'($urandom) & ~s);
      step();
      n++;
    end
    i_region_ack = 4'h0;
    chk("ack_latency", 32'(n), (ack_dly < int'(TIMEOUT)) ? 32'(ack_dly + 1) : 32'(TIMEOUT));
    repeat ($urandom_range(1, 3)) step();
    chk("dtack_hold", 32'(o_dtack), 32'd1);
    release_fcs(8'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] a;
    int r;
    exp_t e;
    i_reset = 1'b1; i_fcs_n = 1'b1; i_match = 1'b0; i_valid_space = 1'b0;
    i_read = 1'b0; i_doe = 1'b0; i_mtcr_n = 1'b1; i_ds_n = 4'hF;
    i_addr = 24'h0; i_region_ack = 4'h0;
    repeat (3) step();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_dtack", 32'(o_dtack), 32'd0);
    chk("rst_sel",   32'(o_region_sel), 32'd0);
    chk("rst_cnt",   32'(o_beat_cnt), 32'd0);
    chk("rst_addr",  32'(o_beat_addr), 32'd0);
    i_reset = 1'b0;
    step();

    run_cycle(24'h100040, 1'b1, 3, 1'b1);    // region 1 read
    run_cycle(24'h000123, 1'b1, 0, 1'b1);    // regions 0 and 2 overlap
    run_cycle(24'h900010, 1'b1, 100, 1'b1);  // no ack: timeout
    run_cycle(24'h100000, 1'b1, 31, 1'b1);   // ack on the timeout cycle
    run_cycle(24'h100000, 1'b1, 2, 1'b0);    // MATCH low
    run_cycle(24'h300000, 1'b1, 2, 1'b1);    // no window hit

    // Write waits in START until DOE
    i_addr = 24'h1000A0; i_match = 1'b1; i_read = 1'b0; i_doe = 1'b0; i_ds_n = 4'h0;
    e.sel = 4'b0010; e.addr = 24'h1000A0; e.err = 1'b0; e.cnt = 8'd1; e.mtack = 1'b0;
    exp_q.push_back(e);
    i_fcs_n = 1'b0;
    step();
    repeat (3) step();
    chk("write_hold", 32'(o_state), 32'd1);
    i_doe = 1'b1;
    step();
    chk("write_data", 32'(o_state), 32'd2);
    i_region_ack = 4'b0010;
    step();
    i_region_ack = 4'h0;
    chk("write_dtack", 32'(o_dtack), 32'd1);
    release_fcs(8'd1);

    // Three-beat burst on the multiple-transfer window
    a = 24'h00AAFC;
    i_addr = a; i_read = 1'b1; i_doe = 1'b0; i_ds_n = 4'hF; i_mtcr_n = 1'b0;
    for (int b = 0; b < 3; b++) begin
      e.sel = 4'b0001; e.addr = beat_addr(a, b); e.err = 1'b0;
      e.cnt = 8'(b + 1); e.mtack = 1'b1;
      exp_q.push_back(e);
    end
    i_fcs_n = 1'b0;
    step();
    chk("burst_start", 32'(o_state), 32'd1);
    step();
    for (int b = 0; b < 3; b++) begin
      chk("burst_data", 32'(o_state), 32'd2);
      step();
      i_region_ack = 4'b0001;
      step();
      i_region_ack = 4'h0;
      chk("burst_dtack", 32'(o_dtack), 32'd1);
      chk("burst_end_mtack", 32'(o_mtack), 32'd1);
      if (b < 2) begin
        i_mtcr_n = 1'b1;
        step();
        chk("mtwait_state", 32'(o_state), 32'd4);
        chk("mtwait_dtack", 32'(o_dtack), 32'd0);
        chk("mtwait_mtack", 32'(o_mtack), 32'd1);
        chk("mtwait_err",   32'(o_bus_err), 32'd0);
        i_mtcr_n = 1'b0;
        step();
        chk("burst_mtack", 32'(o_mtack), 32'd1);
      end
    end
    i_mtcr_n = 1'b1;
    release_fcs(8'd3);

    // Reset while in DATA
    i_addr = 24'h100000; i_read = 1'b1; i_fcs_n = 1'b0;
    step();
    step();
    chk("pre_rst_data", 32'(o_state), 32'd2);
    i_reset = 1'b1;
    step();
    chk("midrst_state", 32'(o_state), 32'd0);
    chk("midrst_outs",
        32'({o_region_sel, o_data_phase, o_dtack, o_mtack, o_bus_err}), 32'd0);
    chk("midrst_addr_cnt", 32'({o_beat_addr, o_beat_cnt}), 32'd0);
    i_reset = 1'b0; i_fcs_n = 1'b1;
    step();

    // Randomised single-beat cycles
    for (int t = 0; t < 24; t++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       a = 24'h100000 | 24'($urandom_range(0, 24'h00FFFF));
        1:       a = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        2:       a = 24'($urandom_range(0, 24'h00FFFF));
        default: a = 24'h200000 + 24'($urandom_range(0, 24'h5FFFFF));
      endcase
      run_cycle(a, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(28, 40))
                                            : int'($urandom_range(0, 7)),
                $urandom_range(0, 7) != 0);
    end

    repeat (2) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
